// File: rtl/spi_rx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spi_rx_pkg
//  Description : Shared constants and FSM state type for the SPI frame
//                receiver. The constants describe the default frame
//                geometry; the top level re-derives them from its own
//                FRAME_BITS parameter.
//  Revision    : 1.0  initial release
// ============================================================================
package spi_rx_pkg;

  localparam int FRAME_BITS      = 512;
  localparam int BYTES_PER_FRAME = FRAME_BITS / 8;
  localparam int BIT_CNT_W       = $clog2(FRAME_BITS) + 1;
  localparam int ADDR_W          = $clog2(BYTES_PER_FRAME);

  typedef enum logic [1:0] {
    WAIT_IDLE = 2'd0,
    IDLE      = 2'd1,
    RECV      = 2'd2
  } spi_rx_state_t;

endpackage
`default_nettype wire

// File: rtl/spi_frame_receiver_sync.sv
`default_nettype none
// ============================================================================
//  Module      : spi_input_sync
//  Description : Multi-stage synchroniser for one asynchronous pin, plus
//                registered single-cycle rise/fall flags.
//  Ports       : clk      - system clock
//                rst      - asynchronous active-high reset
//                in_async - asynchronous input pin
//                sync_o   - synchronised level (last synchroniser stage)
//                dly_o    - sync_o delayed one clk; aligned with rise_o/fall_o
//                rise_o   - 1-cycle flag, synchronised rising edge
//                fall_o   - 1-cycle flag, synchronised falling edge
//  Revision    : 1.0  initial release
// ============================================================================
module spi_input_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic in_async,
  output logic sync_o,
  output logic dly_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   dly_q,  dly_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], in_async};
    dly_d  = sync_q[SYNC_STAGES-1];
    rise_d =  sync_q[SYNC_STAGES-1] & ~dly_q;
    fall_d = ~sync_q[SYNC_STAGES-1] &  dly_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      dly_q  <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      dly_q  <= dly_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign sync_o = sync_q[SYNC_STAGES-1];
  // The edge flags are registered, so the level that produced them is one
  // cycle old by the time they are seen; dly_o is that matching level.
  assign dly_o  = dly_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule
`default_nettype wire

// File: rtl/spi_frame_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : spi_frame_receiver
//  Description : SPI slave frame receiver. Oversamples spi_sck/sdi/CE in the
//                clk domain, deserialises MSB-first bytes and emits one
//                addressed byte write per completed byte. Signals frame_done
//                or frame_err when CE falls.
//  Ports       : clk, reset          - clock, async active-high reset
//                spi_sck, sdi, CE    - asynchronous SPI pins
//                byte_valid          - 1-cycle write strobe
//                byte_addr/byte_data - byte index in frame / assembled byte
//                frame_done          - CE fell after exactly FRAME_BITS bits
//                frame_err           - CE fell after any other bit count
//                busy                - high while receiving a frame
//  Revision    : 1.0  initial release
// ============================================================================
module spi_frame_receiver #(
  parameter int FRAME_BITS  = 512,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          spi_sck,
  input  logic                          sdi,
  input  logic                          CE,
  output logic                          byte_valid,
  output logic [$clog2(FRAME_BITS/8)-1:0] byte_addr,
  output logic [7:0]                    byte_data,
  output logic                          frame_done,
  output logic                          frame_err,
  output logic                          busy
);

  import spi_rx_pkg::*;

  localparam int CNT_W  = $clog2(FRAME_BITS) + 1;
  localparam int AW     = $clog2(FRAME_BITS / 8);
  localparam int WARM_W = $clog2(SYNC_STAGES + 1);

  // ---------------------------------------------------------------- inputs
  logic sck_sync, sck_dly, sck_rise, sck_fall;
  logic ce_sync,  ce_dly,  ce_rise,  ce_fall;
  logic sdi_sync, sdi_dly, sdi_rise, sdi_fall;

  spi_input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sck (
    .clk(clk), .rst(reset), .in_async(spi_sck),
    .sync_o(sck_sync), .dly_o(sck_dly), .rise_o(sck_rise), .fall_o(sck_fall)
  );

  spi_input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ce (
    .clk(clk), .rst(reset), .in_async(CE),
    .sync_o(ce_sync), .dly_o(ce_dly), .rise_o(ce_rise), .fall_o(ce_fall)
  );

  // sdi_dly is the data level aligned with the registered sck_rise flag.
  spi_input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sdi (
    .clk(clk), .rst(reset), .in_async(sdi),
    .sync_o(sdi_sync), .dly_o(sdi_dly), .rise_o(sdi_rise), .fall_o(sdi_fall)
  );

  logic unused_sync_bits;
  assign unused_sync_bits = ^{sck_sync, sck_dly, sck_fall, ce_dly,
                              sdi_sync, sdi_rise, sdi_fall};

  // ----------------------------------------------------------------- state
  spi_rx_state_t     state_q,      state_d;
  logic [CNT_W-1:0]  bit_cnt_q,    bit_cnt_d;
  logic              overflow_q,   overflow_d;
  logic [7:0]        shift_q,      shift_d;
  logic [WARM_W-1:0] warm_q,       warm_d;
  logic              byte_valid_q, byte_valid_d;
  logic [AW-1:0]     byte_addr_q,  byte_addr_d;
  logic [7:0]        byte_data_q,  byte_data_d;
  logic              frame_done_q, frame_done_d;
  logic              frame_err_q,  frame_err_d;

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    overflow_d   = overflow_q;
    shift_d      = shift_q;
    warm_d       = warm_q;
    byte_valid_d = 1'b0;
    byte_addr_d  = byte_addr_q;
    byte_data_d  = byte_data_q;
    frame_done_d = 1'b0;
    frame_err_d  = 1'b0;

    case (state_q)
      // The synchroniser comes out of reset holding 0, which would look like
      // "CE low" even if CE is really high mid-frame. Wait until the chain
      // has been refilled from the pin before trusting ce_sync.
      WAIT_IDLE: begin
        if (warm_q != WARM_W'(SYNC_STAGES)) begin
          warm_d = warm_q + 1'b1;
        end else if (!ce_sync) begin
          state_d = IDLE;
        end
      end

      IDLE: begin
        if (ce_rise) begin
          state_d    = RECV;
          bit_cnt_d  = '0;
          overflow_d = 1'b0;
        end
      end

      RECV: begin
        if (sck_rise) begin
          if (bit_cnt_q < CNT_W'(FRAME_BITS)) begin
            shift_d   = {shift_q[6:0], sdi_dly};
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q[2:0] == 3'b111) begin
              byte_valid_d = 1'b1;
              byte_data_d  = {shift_q[6:0], sdi_dly};
              byte_addr_d  = AW'(bit_cnt_q >> 3);
            end
          end else begin
            overflow_d = 1'b1;
          end
        end
        // Evaluated on the post-bit values so a bit arriving in the same
        // cycle as the CE fall still counts toward the frame.
        if (ce_fall) begin
          state_d = IDLE;
          if (bit_cnt_d == CNT_W'(FRAME_BITS) && !overflow_d) begin
            frame_done_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end

      default: state_d = WAIT_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= WAIT_IDLE;
      bit_cnt_q    <= '0;
      overflow_q   <= 1'b0;
      shift_q      <= '0;
      warm_q       <= '0;
      byte_valid_q <= 1'b0;
      byte_addr_q  <= '0;
      byte_data_q  <= '0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      overflow_q   <= overflow_d;
      shift_q      <= shift_d;
      warm_q       <= warm_d;
      byte_valid_q <= byte_valid_d;
      byte_addr_q  <= byte_addr_d;
      byte_data_q  <= byte_data_d;
      frame_done_q <= frame_done_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign byte_valid = byte_valid_q;
  assign byte_addr  = byte_addr_q;
  assign byte_data  = byte_data_q;
  assign frame_done = frame_done_q;
  assign frame_err  = frame_err_q;
  assign busy       = (state_q == RECV);

endmodule
`default_nettype wire

// File: tb/tb_spi_frame_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_frame_receiver
//  Description : Self-checking bench for spi_frame_receiver. Drives SPI
//                frames at pin level and compares observed byte writes and
//                frame pulses against a bit-list reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_spi_frame_receiver;

  localparam int FB = 512;
  localparam int SS = 2;
  localparam int AW = $clog2(FB / 8);

  logic          clk = 1'b0;
  logic          reset;
  logic          spi_sck;
  logic          sdi;
  logic          CE;
  logic          byte_valid;
  logic [AW-1:0] byte_addr;
  logic [7:0]    byte_data;
  logic          frame_done;
  logic          frame_err;
  logic          busy;

  always #5 clk = ~clk;

  spi_frame_receiver #(.FRAME_BITS(FB), .SYNC_STAGES(SS)) dut (
    .clk(clk), .reset(reset), .spi_sck(spi_sck), .sdi(sdi), .CE(CE),
    .byte_valid(byte_valid), .byte_addr(byte_addr), .byte_data(byte_data),
    .frame_done(frame_done), .frame_err(frame_err), .busy(busy)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  bit          frame_bits[$];
  logic [31:0] exp_addr[$];
  logic [31:0] exp_data[$];
  int          exp_done = 0;
  int          exp_err  = 0;
  logic [31:0] mon_addr[$];
  logic [31:0] mon_data[$];
  int          mon_done = 0;
  int          mon_err  = 0;
  int          ck_idx   = 0;

  // Observer: records every write and pulse, sampled on the falling edge.
  always @(negedge clk) begin
    if (byte_valid === 1'b1) begin
      mon_addr.push_back(32'(byte_addr));
      mon_data.push_back(32'(byte_data));
    end
    if (frame_done === 1'b1) mon_done++;
    if (frame_err === 1'b1)  mon_err++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, " byte_valid"}, 32'(byte_valid), 32'd0);
    chk({tag, " frame_done"}, 32'(frame_done), 32'd0);
    chk({tag, " frame_err"},  32'(frame_err),  32'd0);
    chk({tag, " busy"},       32'(busy),       32'd0);
    chk({tag, " byte_addr"},  32'(byte_addr),  32'd0);
    chk({tag, " byte_data"},  32'(byte_data),  32'd0);
  endtask

  // Fill the frame bit list: mode 0 = byte k is 4*k, 1 = constant c, 2 = random.
  task automatic fill(input int n, input int mode, input logic [7:0] c);
    logic [7:0] b;
    frame_bits.delete();
    b = 8'h00;
    for (int i = 0; i < n; i++) begin
      if (i % 8 == 0) begin
        case (mode)
          0:       b = 8'((i / 8) * 4);
          1:       b = c;
          default: b = 8'($urandom_range(0, 255));
        endcase
      end
      frame_bits.push_back(b[7 - (i % 8)]);
    end
  endtask

  // Reference: every complete byte among the first FB bits becomes one write.
  task automatic model_bytes(input int nbits);
    logic [7:0] b;
    int nb;
    nb = ((nbits > FB) ? FB : nbits) / 8;
    for (int k = 0; k < nb; k++) begin
      b = 8'h00;
      for (int j = 0; j < 8; j++) b = {b[6:0], frame_bits[8 * k + j]};
      exp_addr.push_back(32'(k));
      exp_data.push_back(32'(b));
    end
  endtask

  task automatic model_frame(input int nbits);
    model_bytes(nbits);
    if (nbits == FB) exp_done++;
    else             exp_err++;
  endtask

  task automatic send_bits(input int from, input int to);
    for (int i = from; i < to; i++) begin
      sdi = frame_bits[i];
      repeat (4) @(negedge clk);
      spi_sck = 1'b1;
      repeat (4) @(negedge clk);
      spi_sck = 1'b0;
    end
  endtask

  // merge=1 drops CE in the same instant as the last sck rising edge.
  task automatic run_frame(input int n, input bit merge, input int gap);
    CE = 1'b1;
    repeat (4) @(negedge clk);
    if (merge && n > 0) begin
      send_bits(0, n - 1);
      sdi = frame_bits[n - 1];
      repeat (4) @(negedge clk);
      spi_sck = 1'b1;
      CE      = 1'b0;
      repeat (4) @(negedge clk);
      spi_sck = 1'b0;
    end else begin
      send_bits(0, n);
      repeat (2) @(negedge clk);
      CE = 1'b0;
    end
    repeat (gap) @(negedge clk);
    model_frame(n);
  endtask

  task automatic check(input string tag);
    int lim;
    chk({tag, " write count"}, 32'(mon_addr.size()), 32'(exp_addr.size()));
    lim = (mon_addr.size() < exp_addr.size()) ? mon_addr.size() : exp_addr.size();
    for (int k = ck_idx; k < lim; k++) begin
      chk({tag, " addr"}, mon_addr[k], exp_addr[k]);
      chk({tag, " data"}, mon_data[k], exp_data[k]);
    end
    ck_idx = exp_addr.size();
    chk({tag, " frame_done count"}, 32'(mon_done), 32'(exp_done));
    chk({tag, " frame_err count"},  32'(mon_err),  32'(exp_err));
  endtask

  initial begin
    int n;
    reset   = 1'b1;
    spi_sck = 1'b0;
    sdi     = 1'b0;
    CE      = 1'b0;
    repeat (3) @(negedge clk);
    chk_outputs_zero("reset");
    reset = 1'b0;
    repeat (10) @(negedge clk);

    // Full frame, ramp pattern 00,04,...,FC.
    fill(FB, 0, 8'h00);
    run_frame(FB, 1'b0, 10);
    check("full_ramp");

    // Short frame with a 4-bit partial byte.
    fill(100, 2, 8'h00);
    run_frame(100, 1'b0, 10);
    check("short100");

    // Overlong frame: extra bits are discarded.
    fill(520, 2, 8'h00);
    run_frame(520, 1'b0, 10);
    check("long520");

    // Reset in the middle of a frame with CE held high.
    fill(FB, 2, 8'h00);
    CE = 1'b1;
    repeat (4) @(negedge clk);
    send_bits(0, 200);
    model_bytes(200);
    @(negedge clk);
    #2 reset = 1'b1;
    #1 chk_outputs_zero("mid_reset");
    repeat (3) @(negedge clk);
    reset = 1'b0;
    send_bits(200, 240);
    repeat (6) @(negedge clk);
    check("held_ce");
    chk("held_ce busy", 32'(busy), 32'd0);
    CE = 1'b0;
    repeat (6) @(negedge clk);
    fill(FB, 0, 8'h00);
    run_frame(FB, 1'b0, 10);
    check("after_reset");

    // Back-to-back frames with the minimum CE-low gap.
    fill(FB, 1, 8'hA5);
    run_frame(FB, 1'b0, SS + 1);
    fill(FB, 1, 8'h3C);
    run_frame(FB, 1'b0, 10);
    check("back_to_back");

    // CE falls together with the final sck rising edge.
    fill(FB, 2, 8'h00);
    run_frame(FB, 1'b1, 10);
    check("merged_edge");

    // sck activity with CE low is ignored.
    for (int i = 0; i < 10; i++) begin
      sdi = 1'($urandom_range(0, 1));
      repeat (4) @(negedge clk);
      spi_sck = 1'b1;
      repeat (4) @(negedge clk);
      spi_sck = 1'b0;
    end
    repeat (6) @(negedge clk);
    check("idle_sck");
    chk("idle_sck busy", 32'(busy), 32'd0);

    // Random lengths and data.
    for (int r = 0; r < 4; r++) begin
      n = (r == 0) ? FB : int'($urandom_range(0, 600));
      fill(n, 2, 8'h00);
      run_frame(n, 1'($urandom_range(0, 1)), 10);
      check("random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
